dm_arbiter: RTL and testbench



---
 rtl/dm_arb_pkg.sv | 8 +
 rtl/dm_arb_pick.sv | 28 ++
 rtl/dm_arbiter.sv | 112 +++++++++++
 tb/tb_dm_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared types and widths for the data-memory arbiter
package dm_arb_pkg;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_CPU, OWN_DMA} owner_t;
endpackage

// File: rtl/dm_arb_pick.sv
// dm_arb_pick: CPU-priority grant selection with a saturating DMA deferral counter
module dm_arb_pick #(
    parameter int MAX_DEFER = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_cpu_req,
    input  logic i_dma_valid,
    input  logic i_idle,
    output logic o_grant_cpu,
    output logic o_grant_dma
);
    localparam int CW = $clog2(MAX_DEFER + 1);
    logic [CW-1:0] r_defer_cnt;
    logic          w_dma_due;
    assign w_dma_due   = r_defer_cnt == CW'(MAX_DEFER);
    assign o_grant_dma = i_idle & i_dma_valid & (~i_cpu_req | w_dma_due);
    assign o_grant_cpu = i_idle & i_cpu_req & ~o_grant_dma;
    // a CPU grant can only coincide with a pending DMA while the counter is below MAX_DEFER
    always_ff @(posedge clk) begin
        if (reset)
            r_defer_cnt <= '0;
        else if (o_grant_dma)
            r_defer_cnt <= '0;
        else if (o_grant_cpu)
            r_defer_cnt <= i_dma_valid ? r_defer_cnt + 1'b1 : '0;
    end
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data-memory port between the CPU M stage and a DMA requester
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int MAX_DEFER = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [BW-1:0] cpu_byteen,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dma_valid,
    output logic          dma_ready,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [BW-1:0] dma_byteen,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [BW-1:0] mem_byteen,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int LW = 3;
    state_t        r_state, w_next;
    owner_t        r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [BW-1:0] r_be;
    logic [DW-1:0] r_wdata, r_resp, r_cpu_hold;
    logic [LW-1:0] r_lat;
    logic          w_idle, w_grant_cpu, w_grant_dma, w_last;

    assign w_idle = (r_state == IDLE) & ~reset;
    assign w_last = (r_state == WAIT) & (r_lat == LW'(1));

    dm_arb_pick #(.MAX_DEFER(MAX_DEFER)) u_pick (
        .clk         (clk),
        .reset       (reset),
        .i_cpu_req   (cpu_req),
        .i_dma_valid (dma_valid),
        .i_idle      (w_idle),
        .o_grant_cpu (w_grant_cpu),
        .o_grant_dma (w_grant_dma)
    );

    always_ff @(posedge clk)
        r_state <= reset ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  w_next = (w_grant_cpu | w_grant_dma) ? ISSUE : IDLE;
            ISSUE: w_next = WAIT;
            WAIT:  w_next = w_last ? RESP : WAIT;
            RESP:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= OWN_CPU;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_lat      <= '0;
            r_resp     <= '0;
            r_cpu_hold <= '0;
        end else begin
            if (w_grant_cpu | w_grant_dma) begin
                r_owner <= w_grant_dma ? OWN_DMA : OWN_CPU;
                r_we    <= w_grant_dma ? dma_we : cpu_we;
                r_addr  <= w_grant_dma ? dma_addr : cpu_addr;
                r_be    <= w_grant_dma ? dma_byteen : cpu_byteen;
                r_wdata <= w_grant_dma ? dma_wdata : cpu_wdata;
            end
            if (r_state == ISSUE)
                r_lat <= LW'(RD_LAT);
            else if (r_state == WAIT)
                r_lat <= r_lat - 1'b1;
            if (w_last)
                r_resp <= mem_rdata;
            if (cpu_ack)
                r_cpu_hold <= r_resp;
        end
    end

    // cpu_rdata keeps the last CPU response so DMA traffic never disturbs it
    always_comb begin
        mem_en     = r_state == ISSUE;
        mem_we     = mem_en & r_we;
        mem_addr   = r_addr;
        mem_byteen = r_be;
        mem_wdata  = r_wdata;
        cpu_ack    = (r_state == RESP) & (r_owner == OWN_CPU);
        dma_rvalid = (r_state == RESP) & (r_owner == OWN_DMA);
        dma_ready  = w_grant_dma;
        cpu_stall  = cpu_req & ~cpu_ack;
        cpu_rdata  = cpu_ack ? r_resp : r_cpu_hold;
        dma_rdata  = (dma_rvalid & ~r_we) ? r_resp : '0;
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: two arbiters (RD_LAT 1/MAX_DEFER 4 and RD_LAT 3/MAX_DEFER 2) checked each cycle against a transaction-timeline model
module tb_dm_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic armed = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic        cpu_req[2], cpu_we[2], dma_valid[2], dma_we[2];
    logic [31:0] cpu_addr[2], cpu_wdata[2], dma_addr[2], dma_wdata[2], mem_rdata[2];
    logic [3:0]  cpu_byteen[2], dma_byteen[2];
    logic [31:0] cpu_rdata[2], dma_rdata[2], mem_addr[2], mem_wdata[2];
    logic [3:0]  mem_byteen[2];
    logic        cpu_ack[2], cpu_stall[2], dma_ready[2], dma_rvalid[2], mem_en[2], mem_we[2];

    int          m_free[2], m_iss[2], m_done[2], m_defer[2];
    logic        m_dma[2], m_we[2];
    logic [31:0] m_addr[2], m_wd[2], m_hold[2];
    logic [3:0]  m_be[2];
    string       order[2];

    int          mem_iss[2], n_en[2], n_rdy[2], en_cyc[2];
    logic [31:0] mem_ra[2], en_addr[2], en_wd[2];
    logic [3:0]  en_be[2];
    logic        en_we[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dm_arbiter #(.RD_LAT(g == 0 ? 1 : 3), .MAX_DEFER(g == 0 ? 4 : 2)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .cpu_req    (cpu_req[g]),
            .cpu_we     (cpu_we[g]),
            .cpu_addr   (cpu_addr[g]),
            .cpu_byteen (cpu_byteen[g]),
            .cpu_wdata  (cpu_wdata[g]),
            .cpu_rdata  (cpu_rdata[g]),
            .cpu_ack    (cpu_ack[g]),
            .cpu_stall  (cpu_stall[g]),
            .dma_valid  (dma_valid[g]),
            .dma_ready  (dma_ready[g]),
            .dma_we     (dma_we[g]),
            .dma_addr   (dma_addr[g]),
            .dma_byteen (dma_byteen[g]),
            .dma_wdata  (dma_wdata[g]),
            .dma_rvalid (dma_rvalid[g]),
            .dma_rdata  (dma_rdata[g]),
            .mem_en     (mem_en[g]),
            .mem_we     (mem_we[g]),
            .mem_addr   (mem_addr[g]),
            .mem_byteen (mem_byteen[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_rdata  (mem_rdata[g])
        );
    end

    function automatic int lat_of(input int k);
        return k == 0 ? 1 : 3;
    endfunction

    function automatic int md_of(input int k);
        return k == 0 ? 4 : 2;
    endfunction

    function automatic logic [31:0] mem_img(input logic [31:0] a);
        return a == 32'h100 ? 32'hDEAD_BEEF : a == 32'h40 ? 32'hCAFE_F00D : {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // memory returns data exactly RD_LAT cycles after the strobe, garbage otherwise
    always_comb
        for (int k = 0; k < 2; k++)
            mem_rdata[k] = (cyc == mem_iss[k] + lat_of(k)) ? mem_img(mem_ra[k]) : 32'hBAD0_BAD0;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic        g_cpu, g_dma, done;
            logic [31:0] rsp;
            if (mem_en[k] === 1'b1) begin
                mem_iss[k] = cyc;
                mem_ra[k]  = mem_addr[k];
                n_en[k]++;
                en_cyc[k]  = cyc;
                en_addr[k] = mem_addr[k];
                en_be[k]   = mem_byteen[k];
                en_wd[k]   = mem_wdata[k];
                en_we[k]   = mem_we[k];
            end
            if (dma_ready[k] === 1'b1)
                n_rdy[k]++;
            rsp   = mem_img(m_addr[k]);
            done  = cyc == m_done[k];
            g_dma = !reset && cyc >= m_free[k] && dma_valid[k] && (!cpu_req[k] || m_defer[k] == md_of(k));
            g_cpu = !reset && cyc >= m_free[k] && cpu_req[k] && !g_dma;
            if (armed) begin
                chk($sformatf("mem_en%0d", k), mem_en[k], cyc == m_iss[k]);
                chk($sformatf("mem_we%0d", k), mem_we[k], cyc == m_iss[k] && m_we[k]);
                chk($sformatf("mem_addr%0d", k), mem_addr[k], m_addr[k]);
                chk($sformatf("mem_byteen%0d", k), mem_byteen[k], m_be[k]);
                chk($sformatf("mem_wdata%0d", k), mem_wdata[k], m_wd[k]);
                chk($sformatf("cpu_ack%0d", k), cpu_ack[k], done && !m_dma[k]);
                chk($sformatf("dma_rvalid%0d", k), dma_rvalid[k], done && m_dma[k]);
                chk($sformatf("cpu_rdata%0d", k), cpu_rdata[k], (done && !m_dma[k]) ? rsp : m_hold[k]);
                chk($sformatf("dma_rdata%0d", k), dma_rdata[k], (done && m_dma[k] && !m_we[k]) ? rsp : 32'h0);
                chk($sformatf("cpu_stall%0d", k), cpu_stall[k], cpu_req[k] && !(done && !m_dma[k]));
                chk($sformatf("dma_ready%0d", k), dma_ready[k], g_dma);
            end
            if (done && !m_dma[k])
                m_hold[k] = rsp;
            if (g_cpu || g_dma) begin
                m_iss[k]   = cyc + 1;
                m_done[k]  = cyc + 2 + lat_of(k);
                m_free[k]  = cyc + 3 + lat_of(k);
                m_dma[k]   = g_dma;
                m_we[k]    = g_dma ? dma_we[k] : cpu_we[k];
                m_addr[k]  = g_dma ? dma_addr[k] : cpu_addr[k];
                m_be[k]    = g_dma ? dma_byteen[k] : cpu_byteen[k];
                m_wd[k]    = g_dma ? dma_wdata[k] : cpu_wdata[k];
                m_defer[k] = (g_dma || !dma_valid[k]) ? 0 : (m_defer[k] < md_of(k) ? m_defer[k] + 1 : m_defer[k]);
                if (g_dma)
                    order[k] = {order[k], "D"};
                else
                    order[k] = {order[k], "C"};
            end
            if (reset) begin
                m_free[k]  = cyc + 1;
                m_iss[k]   = -1;
                m_done[k]  = -1;
                m_defer[k] = 0;
                m_dma[k]   = 1'b0;
                m_we[k]    = 1'b0;
                m_addr[k]  = '0;
                m_be[k]    = '0;
                m_wd[k]    = '0;
                m_hold[k]  = '0;
            end
        end
    end

    task automatic cpu_op(input int k, input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, output int t_req, output int t_ack,
                          output logic [31:0] rd, output int n_stall);
        cpu_req[k]    = 1'b1;
        cpu_we[k]     = we;
        cpu_addr[k]   = a;
        cpu_byteen[k] = be;
        cpu_wdata[k]  = wd;
        t_req   = cyc;
        t_ack   = -1;
        rd      = '0;
        n_stall = 0;
        for (int i = 0; i < 60 && t_ack < 0; i++) begin
            @(negedge clk);
            if (cpu_stall[k]) n_stall++;
            if (cpu_ack[k]) begin
                t_ack = cyc;
                rd    = cpu_rdata[k];
            end
            @(posedge clk);
            #1;
        end
        cpu_req[k] = 1'b0;
        chk("cpu_ack_seen", t_ack >= 0, 1'b1);
    endtask

    task automatic dma_op(input int k, input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, output int t_rdy, output int t_rv, output logic [31:0] rd);
        dma_valid[k]  = 1'b1;
        dma_we[k]     = we;
        dma_addr[k]   = a;
        dma_byteen[k] = be;
        dma_wdata[k]  = wd;
        t_rdy = -1;
        t_rv  = -1;
        rd    = '0;
        for (int i = 0; i < 60 && t_rv < 0; i++) begin
            @(negedge clk);
            if (dma_ready[k] && t_rdy < 0) t_rdy = cyc;
            if (dma_rvalid[k]) begin
                t_rv = cyc;
                rd   = dma_rdata[k];
            end
            @(posedge clk);
            #1;
            if (t_rdy >= 0) dma_valid[k] = 1'b0;
        end
        dma_valid[k] = 1'b0;
        chk("dma_rvalid_seen", t_rv >= 0, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, limit 400000 expected earlier");
        $fatal(1);
    end

    initial begin
        int          tr, ta, ns, e0, r0;
        logic [31:0] rd;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cpu_req[k] = 0; cpu_we[k] = 0; cpu_addr[k] = 0; cpu_byteen[k] = 0; cpu_wdata[k] = 0;
            dma_valid[k] = 0; dma_we[k] = 0; dma_addr[k] = 0; dma_byteen[k] = 0; dma_wdata[k] = 0;
            mem_iss[k] = -100; n_en[k] = 0; n_rdy[k] = 0; en_cyc[k] = -1;
            m_free[k] = 0; m_iss[k] = -1; m_done[k] = -1; m_defer[k] = 0; order[k] = "";
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        chk("rst_cpu_rdata", cpu_rdata[0], 32'h0);
        chk("rst_mem_addr", mem_addr[1], 32'h0);
        chk("rst_mem_en", mem_en[0], 1'b0);
        chk("rst_cpu_ack", cpu_ack[0], 1'b0);
        @(posedge clk);
        #1;
        // single CPU read, RD_LAT 1
        e0 = n_en[0];
        cpu_op(0, 1'b0, 32'h100, 4'hF, 32'h0, tr, ta, rd, ns);
        chk("rd_ack_lat", ta - tr, 3);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_stall_cycles", ns, 3);
        chk("rd_en_lat", en_cyc[0] - tr, 1);
        chk("rd_en_count", n_en[0] - e0, 1);
        // CPU write with partial byte enables
        e0 = n_en[0];
        cpu_op(0, 1'b1, 32'h200, 4'b0011, 32'h1234, tr, ta, rd, ns);
        repeat (3) @(posedge clk);
        #1;
        chk("wr_ack_lat", ta - tr, 3);
        chk("wr_en_count", n_en[0] - e0, 1);
        chk("wr_addr", en_addr[0], 32'h200);
        chk("wr_be", en_be[0], 4'b0011);
        chk("wr_data", en_wd[0], 32'h1234);
        chk("wr_we", en_we[0], 1'b1);
        // both requesting continuously, MAX_DEFER 4
        order[0] = "";
        r0 = n_rdy[0];
        fork
            begin
                int a0, a1, a3; logic [31:0] a2;
                for (int i = 0; i < 10; i++)
                    cpu_op(0, i[0], 32'h1000 + 32'(i * 4), 4'hF, 32'(i * 3), a0, a1, a2, a3);
            end
            begin
                int b0, b1; logic [31:0] b2;
                for (int j = 0; j < 2; j++)
                    dma_op(0, 1'b0, 32'h2000 + 32'(j * 4), 4'hF, 32'h0, b0, b1, b2);
            end
        join
        n_tests++;
        if (order[0] != "CCCCDCCCCDCC") begin
            n_fail++;
            $display("FAIL grant_order0: got %s expected CCCCDCCCCDCC", order[0]);
        end
        chk("fair_ready_pulses", n_rdy[0] - r0, 2);
        // DMA-only traffic on the RD_LAT 3 instance
        dma_op(1, 1'b0, 32'h40, 4'hF, 32'h0, tr, ta, rd);
        chk("dma_rd_lat", ta - tr, 5);
        chk("dma_rd_data", rd, 32'hCAFE_F00D);
        dma_op(1, 1'b1, 32'h80, 4'hF, 32'h55, tr, ta, rd);
        chk("dma_wr_lat", ta - tr, 5);
        chk("dma_wr_data", rd, 32'h0);
        cpu_op(1, 1'b0, 32'h100, 4'hF, 32'h0, tr, ta, rd, ns);
        chk("cpu3_ack_lat", ta - tr, 5);
        chk("cpu3_data", rd, 32'hDEAD_BEEF);
        chk("cpu3_stall_cycles", ns, 5);
        // both requesting, MAX_DEFER 2
        order[1] = "";
        fork
            begin
                int c0, c1, c3; logic [31:0] c2;
                for (int i = 0; i < 4; i++)
                    cpu_op(1, 1'b0, 32'h3000 + 32'(i * 4), 4'hF, 32'h0, c0, c1, c2, c3);
            end
            begin
                int d0, d1; logic [31:0] d2;
                for (int j = 0; j < 2; j++)
                    dma_op(1, j[0], 32'h4000 + 32'(j * 4), 4'h1, 32'h77, d0, d1, d2);
            end
        join
        n_tests++;
        if (order[1] != "CCDCCD") begin
            n_fail++;
            $display("FAIL grant_order1: got %s expected CCDCCD", order[1]);
        end
        // reset during WAIT of a CPU read
        @(posedge clk);
        #1;
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h300; cpu_byteen[0] = 4'hF;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cpu_req[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_mem_addr", mem_addr[0], 32'h0);
        chk("mid_rst_cpu_rdata", cpu_rdata[0], 32'h0);
        chk("mid_rst_ack", cpu_ack[0], 1'b0);
        chk("mid_rst_stall", cpu_stall[0], 1'b0);
        chk("mid_rst_en", mem_en[0], 1'b0);
        repeat (4) @(posedge clk);
        #1;
        cpu_op(0, 1'b0, 32'h100, 4'hF, 32'h0, tr, ta, rd, ns);
        chk("post_rst_lat", ta - tr, 3);
        chk("post_rst_data", rd, 32'hDEAD_BEEF);
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
